spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//  Output-side counterpart of binary_spike_gen: converts if_network spike_out trains into per-neuron
//  spike counts over a programmable window and selects the winning (max-count) neuron.
//  Sits between if_network.spike_out and the config register block, which starts windows and reads results.
// PARAMETERS
//  NUM_INPUTS    4   spike lines observed (= network NUM_OUTPUTS)
//  COUNT_WIDTH   16  bits per spike counter
//  WINDOW_WIDTH  16  bits of window length (cycles)
//  IDX_WIDTH     $clog2(NUM_INPUTS)>0 ? $clog2(NUM_INPUTS) : 1; width of winner index
// PORTS
//  clk           in   1                        system clock (S_AXI_ACLK at top)
//  rst           in   1                        asynchronous reset, active-high
//  start         in   1                        request new window; accepted only when busy=0
//  abort         in   1                        sync abort of an active window/scan
//  window_len    in   WINDOW_WIDTH             window length W, sampled when start accepted
//  spike_in      in   NUM_INPUTS               one spike per line per cycle max
//  busy          out  1                        high in COUNT and SCAN
//  done          out  1                        1-cycle pulse when results valid
//  counts        out  NUM_INPUTS*COUNT_WIDTH   counter i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//  winner_idx    out  IDX_WIDTH                index of max count
//  winner_valid  out  1                        max count > 0
//  overflow      out  1                        sticky per window: some counter hit its max
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, counts=0, winner_idx=0, winner_valid=0, overflow=0, timer=0.
//  FSM IDLE -> COUNT -> SCAN -> IDLE.
//  IDLE: start=1 at edge E0 -> clear counts/overflow/winner_*; latch W; W>0 -> COUNT, W=0 -> SCAN.
//  COUNT: spike_in sampled on exactly the W edges after E0; counter i += spike_in[i]; timer down;
//   after the W-th sample -> SCAN.
//  SCAN: one index per cycle, i=0..NUM_INPUTS-1 (NUM_INPUTS cycles); running max replaced only on
//   strictly greater count -> ties resolve to lowest index; winner_idx/winner_valid update at end.
//  done pulses high for one cycle, exactly W+NUM_INPUTS+1 cycles after E0; state IDLE same cycle.
//  Results (counts, winner_*, overflow) held stable until next accepted start or reset.
//  start while busy=1: ignored, no queuing. start and abort same cycle in IDLE: start wins.
//  abort in COUNT/SCAN: -> IDLE next edge, no done, winner_valid=0, counts keep partial values.
//  abort in IDLE: no effect. Async rst anytime: all outputs to reset values immediately.
//  Counters unsigned; overflow handling per CONFIGURATION. winner_idx reflects final counts.
// CONFIGURATION
//  Macro SPIKE_DEC_SATURATE_EN:
//   defined: counter at 2^COUNT_WIDTH-1 holds on further spikes; overflow set sticky for window.
//   undefined: counters wrap modulo 2^COUNT_WIDTH; overflow tied 0.
// TESTING
//  1 N=4,W=10,spike_in=4'b0100 constant -> counts={0,10,0,0}(i3..i0), winner_idx=2,
//    winner_valid=1, done exactly 15 cycles after start edge.
//  2 W=5,spike_in=4'b1010 -> counts[1]=counts[3]=5, winner_idx=1 (tie -> lowest).
//  3 W=0 -> done 5 cycles after start, all counts 0, winner_valid=0, winner_idx=0.
//  4 COUNT_WIDTH=4,W=20,spike_in=4'hF -> with macro counts=15 each, overflow=1;
//    without macro counts=4 each, overflow=0.
//  5 start again at cycle 3 of a W=10 window -> ignored; original done timing/results unchanged.
//  6 abort at cycle 4 of W=10 -> IDLE, no done, winner_valid=0; rst mid-SCAN -> all outputs 0 at once.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Converts spike trains from the network output into per-neuron spike counts
// over a programmable window. After the window it picks the neuron with the
// highest count. If several neurons share the highest count, the lowest index
// wins.
//
// Optional build macro:
//   SPIKE_DEC_SATURATE_EN
//     - defined:   a counter stops at its maximum value, and the sticky
//                  overflow flag is set for that window.
//     - undefined: counters wrap modulo 2^COUNT_WIDTH, and overflow is tied 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   start        request a new window; accepted only while busy=0
//   abort        synchronous abort of an active window or scan
//   window_len   window length in cycles, sampled when start is accepted
//   spike_in     one spike bit per observed line per cycle
//   busy         high while counting or scanning
//   done         one-cycle pulse when results are valid
//   counts       packed counters; counter i sits at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   winner_idx   index of the maximum count
//   winner_valid high when the maximum count is non-zero
//   overflow     sticky per window: some counter reached its maximum
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int NUM_INPUTS   = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int IDX_WIDTH    = ($clog2(NUM_INPUTS) > 0) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [WINDOW_WIDTH-1:0]           window_len,
    input  logic [NUM_INPUTS-1:0]             spike_in,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_INPUTS*COUNT_WIDTH-1:0] counts,
    output logic [IDX_WIDTH-1:0]              winner_idx,
    output logic                              winner_valid,
    output logic                              overflow
);

    // Scan index runs 0..NUM_INPUTS. The final value is the step that publishes the winner.
    localparam int SCAN_WIDTH = $clog2(NUM_INPUTS + 1);
    localparam logic [SCAN_WIDTH-1:0]  SCAN_LAST = SCAN_WIDTH'(NUM_INPUTS);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;

    logic [1:0]              state_r;
    logic [WINDOW_WIDTH-1:0] timer_r;
    logic [COUNT_WIDTH-1:0]  counts_r [NUM_INPUTS];
    logic [SCAN_WIDTH-1:0]   scan_idx_r;
    logic [COUNT_WIDTH-1:0]  max_cnt_r;
    logic [IDX_WIDTH-1:0]    max_idx_r;
    logic [IDX_WIDTH-1:0]    winner_idx_r;
    logic                    winner_valid_r;
    logic                    done_r;
    logic                    busy_r;
    logic                    start_accept_s;
    logic                    count_en_s;
    logic [COUNT_WIDTH-1:0]  scan_cnt_s;

    // Next value of one counter given its current value and this cycle's spike.
    function automatic logic [COUNT_WIDTH-1:0] next_count(
        input logic [COUNT_WIDTH-1:0] cur,
        input logic                   spike
    );
`ifdef SPIKE_DEC_SATURATE_EN
        if (spike && (cur != CNT_MAX)) begin
            next_count = cur + COUNT_WIDTH'(1);
        end else begin
            next_count = cur;
        end
`else
        next_count = cur + COUNT_WIDTH'(spike);
`endif
    endfunction

    // Decode start acceptance, the counting enable, and the counter currently being scanned.
    always_comb begin
        start_accept_s = (state_r == ST_IDLE) && start;
        count_en_s     = (state_r == ST_COUNT) && !abort;
        scan_cnt_s     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (scan_idx_r == SCAN_WIDTH'(i)) begin
                scan_cnt_s = counts_r[i];
            end else begin
                scan_cnt_s = scan_cnt_s;
            end
        end
    end

    // Spike counters: cleared when a start is accepted, advanced while counting.
    // After an abort they keep their partial values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) counts_r[i] <= '0;
        end else if (start_accept_s) begin
            for (int i = 0; i < NUM_INPUTS; i++) counts_r[i] <= '0;
        end else if (count_en_s) begin
            for (int i = 0; i < NUM_INPUTS; i++) counts_r[i] <= next_count(counts_r[i], spike_in[i]);
        end
    end

`ifdef SPIKE_DEC_SATURATE_EN
    logic                  overflow_r;
    logic [NUM_INPUTS-1:0] hit_max_s;

    // A counter hits its maximum when a spike lands on it at max-1 or at max.
    always_comb begin
        hit_max_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            hit_max_s[i] = spike_in[i] && (counts_r[i] >= (CNT_MAX - COUNT_WIDTH'(1)));
        end
    end

    // Sticky overflow flag, cleared when a new window starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (start_accept_s) begin
            overflow_r <= 1'b0;
        end else if (count_en_s && (|hit_max_s)) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

    // Window sequencer: IDLE -> COUNT (W samples) -> SCAN (one index per cycle plus a publish step) -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            timer_r        <= '0;
            scan_idx_r     <= '0;
            max_cnt_r      <= '0;
            max_idx_r      <= '0;
            winner_idx_r   <= '0;
            winner_valid_r <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r         <= 1'b1;
                        timer_r        <= window_len;
                        scan_idx_r     <= '0;
                        max_cnt_r      <= '0;
                        max_idx_r      <= '0;
                        winner_idx_r   <= '0;
                        winner_valid_r <= 1'b0;
                        state_r        <= (window_len == '0) ? ST_SCAN : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        busy_r         <= 1'b0;
                        winner_valid_r <= 1'b0;
                        state_r        <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r - WINDOW_WIDTH'(1);
                        if (timer_r == WINDOW_WIDTH'(1)) begin
                            state_r <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        busy_r         <= 1'b0;
                        winner_valid_r <= 1'b0;
                        state_r        <= ST_IDLE;
                    end else if (scan_idx_r == SCAN_LAST) begin
                        winner_idx_r   <= max_idx_r;
                        winner_valid_r <= (max_cnt_r != '0);
                        done_r         <= 1'b1;
                        busy_r         <= 1'b0;
                        state_r        <= ST_IDLE;
                    end else begin
                        // Replace the running maximum only on a strictly greater count, so ties keep the lower index.
                        if (scan_cnt_s > max_cnt_r) begin
                            max_cnt_r <= scan_cnt_s;
                            max_idx_r <= IDX_WIDTH'(scan_idx_r);
                        end
                        scan_idx_r <= scan_idx_r + SCAN_WIDTH'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_counts
        assign counts[g*COUNT_WIDTH +: COUNT_WIDTH] = counts_r[g];
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign winner_idx   = winner_idx_r;
    assign winner_valid = winner_valid_r;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for spike_rate_decoder.
// The DUT is built with 4-bit counters, so wrap or saturation behaviour shows
// up within short windows.
// Expected counts come from plain per-line spike totals, then wrap or clamp.
// The winner is the first index holding the largest expected count.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int NI   = 4;
    localparam int CW   = 4;
    localparam int WW   = 16;
    localparam int CMAX = (1 << CW) - 1;
`ifdef SPIKE_DEC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic           abort;
    logic [WW-1:0]  window_len;
    logic [NI-1:0]  spike_in;
    logic           busy;
    logic           done;
    logic [NI*CW-1:0] counts;
    logic [1:0]     winner_idx;
    logic           winner_valid;
    logic           overflow;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Results of the most recent window, filled in by run_window.
    int done_at;
    int done_pulses;
    int busy_bad;
    logic [NI*CW-1:0] exp_counts;
    logic [1:0]       exp_idx;
    logic             exp_valid;
    logic             exp_ovf;

    spike_rate_decoder #(
        .NUM_INPUTS   (NI),
        .COUNT_WIDTH  (CW),
        .WINDOW_WIDTH (WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .window_len   (window_len),
        .spike_in     (spike_in),
        .busy         (busy),
        .done         (done),
        .counts       (counts),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one window of length w and record when done arrived.
    // The expected results are derived from the spikes that fell inside the window.
    task automatic run_window(input int w, input logic [3:0] pat, input bit rnd,
                              input int restart_at, input bit abort_with_start);
        int raw [NI];
        int val [NI];
        int mx;
        logic [3:0] s;
        for (int i = 0; i < NI; i++) raw[i] = 0;
        done_at = -1; done_pulses = 0; busy_bad = 0;
        window_len = 16'(w); start = 1'b1; abort = abort_with_start; spike_in = 4'($urandom);
        step();
        start = 1'b0; abort = 1'b0; window_len = 16'($urandom);
        for (int k = 1; k <= w + NI + 2; k++) begin
            s = rnd ? 4'($urandom) : pat;
            if (k <= w) begin
                spike_in = s;
                for (int i = 0; i < NI; i++) raw[i] += int'(s[i]);
            end else begin
                spike_in = 4'($urandom);
            end
            start = (k == restart_at);
            if (start) window_len = 16'd3;
            step();
            start = 1'b0;
            if (done === 1'b1) begin
                done_pulses++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== (k < w + NI + 1)) busy_bad++;
        end
        exp_ovf = 1'b0; mx = 0; exp_idx = 2'd0;
        for (int i = 0; i < NI; i++) begin
            val[i] = SAT ? ((raw[i] > CMAX) ? CMAX : raw[i]) : (raw[i] % (CMAX + 1));
            if (SAT && raw[i] >= CMAX) exp_ovf = 1'b1;
            exp_counts[i*CW +: CW] = 4'(val[i]);
            if (val[i] > mx) begin mx = val[i]; exp_idx = 2'(i); end
        end
        exp_valid = (mx > 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; window_len = '0; spike_in = '0;
        repeat (3) step();
        cmp_cnt++;
        if ({busy, done, counts, winner_idx, winner_valid, overflow} !== 22'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, counts, winner_idx, winner_valid, overflow});
        end
        rst = 1'b0;
        step();
        cmp_cnt++;
        if ({busy, done, counts, winner_valid} !== 19'd0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got %h expected 0", {busy, done, counts, winner_valid});
        end
    endtask

    task automatic test_single_line();
        run_window(10, 4'b0100, 1'b0, -1, 1'b0);
        cmp_cnt++;
        if (done_at !== 15 || done_pulses !== 1) begin
            err_cnt++;
            $display("FAIL single_done_timing: got cycle %0d pulses %0d expected cycle 15 pulses 1", done_at, done_pulses);
        end
        cmp_cnt++;
        if (counts !== 16'h0a00 || counts !== exp_counts) begin
            err_cnt++;
            $display("FAIL single_counts: got %h expected 0a00", counts);
        end
        cmp_cnt++;
        if (winner_idx !== 2'd2 || winner_valid !== 1'b1 || busy_bad !== 0) begin
            err_cnt++;
            $display("FAIL single_winner: got idx %0d valid %0d busy_bad %0d expected idx 2 valid 1 busy_bad 0", winner_idx, winner_valid, busy_bad);
        end
    endtask

    task automatic test_tie();
        run_window(5, 4'b1010, 1'b0, -1, 1'b0);
        cmp_cnt++;
        if (counts !== 16'h5050 || winner_idx !== 2'd1 || winner_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL tie_lowest: got counts %h idx %0d valid %0d expected 5050 idx 1 valid 1", counts, winner_idx, winner_valid);
        end
    endtask

    task automatic test_zero_window();
        run_window(0, 4'hF, 1'b0, -1, 1'b0);
        cmp_cnt++;
        if (done_at !== 5 || done_pulses !== 1) begin
            err_cnt++;
            $display("FAIL zero_done_timing: got cycle %0d pulses %0d expected cycle 5 pulses 1", done_at, done_pulses);
        end
        cmp_cnt++;
        if (counts !== 16'h0 || winner_valid !== 1'b0 || winner_idx !== 2'd0) begin
            err_cnt++;
            $display("FAIL zero_results: got counts %h idx %0d valid %0d expected 0 0 0", counts, winner_idx, winner_valid);
        end
    endtask

    task automatic test_overflow();
        logic [CW-1:0] lane;
        lane = SAT ? 4'd15 : 4'd4;
        run_window(20, 4'hF, 1'b0, -1, 1'b0);
        cmp_cnt++;
        if (counts !== {NI{lane}} || overflow !== SAT) begin
            err_cnt++;
            $display("FAIL overflow_counts: got counts %h ovf %0d expected %h ovf %0d", counts, overflow, {NI{lane}}, SAT);
        end
    endtask

    task automatic test_restart_ignored();
        run_window(10, 4'b0000, 1'b1, 3, 1'b0);
        cmp_cnt++;
        if (done_at !== 15 || done_pulses !== 1 || busy_bad !== 0) begin
            err_cnt++;
            $display("FAIL restart_timing: got cycle %0d pulses %0d busy_bad %0d expected 15 1 0", done_at, done_pulses, busy_bad);
        end
        cmp_cnt++;
        if (counts !== exp_counts || winner_idx !== exp_idx || winner_valid !== exp_valid) begin
            err_cnt++;
            $display("FAIL restart_results: got %h/%0d/%0d expected %h/%0d/%0d", counts, winner_idx, winner_valid, exp_counts, exp_idx, exp_valid);
        end
    endtask

    task automatic test_start_abort_idle();
        run_window(7, 4'b0000, 1'b1, -1, 1'b1);
        cmp_cnt++;
        if (done_at !== 12 || counts !== exp_counts || winner_idx !== exp_idx || winner_valid !== exp_valid) begin
            err_cnt++;
            $display("FAIL start_beats_abort: got cycle %0d %h/%0d/%0d expected 12 %h/%0d/%0d", done_at, counts, winner_idx, winner_valid, exp_counts, exp_idx, exp_valid);
        end
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        window_len = 16'd10; spike_in = 4'b0010; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b0 || winner_valid !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_idle: got busy %0d valid %0d done %0d expected 0 0 0", busy, winner_valid, done);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (done === 1'b1) seen++;
        end
        cmp_cnt++;
        if (seen !== 0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_no_done: got %0d done pulses busy %0d expected 0 0", seen, busy);
        end
    endtask

    task automatic test_rst_mid_scan();
        window_len = 16'd2; spike_in = 4'hF; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if ({busy, done, counts, winner_idx, winner_valid, overflow} !== 22'd0) begin
            err_cnt++;
            $display("FAIL rst_mid_scan: got %h expected 0", {busy, done, counts, winner_idx, winner_valid, overflow});
        end
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int w;
        for (int n = 0; n < 8; n++) begin
            w = $urandom_range(0, 40);
            run_window(w, 4'b0000, 1'b1, -1, 1'b0);
            cmp_cnt++;
            if (done_at !== w + NI + 1 || done_pulses !== 1 || busy_bad !== 0) begin
                err_cnt++;
                $display("FAIL rand_timing: W=%0d got cycle %0d pulses %0d busy_bad %0d expected %0d 1 0", w, done_at, done_pulses, busy_bad, w + NI + 1);
            end
            cmp_cnt++;
            if (counts !== exp_counts || winner_idx !== exp_idx || winner_valid !== exp_valid || overflow !== exp_ovf) begin
                err_cnt++;
                $display("FAIL rand_results: W=%0d got %h/%0d/%0d/%0d expected %h/%0d/%0d/%0d", w, counts, winner_idx, winner_valid, overflow, exp_counts, exp_idx, exp_valid, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_tie();
        test_zero_window();
        test_overflow();
        test_restart_ignored();
        test_start_abort_idle();
        test_abort();
        test_rst_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
